// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shift unit: operation modes and FSM states.
package shift_pkg;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// One single-bit shift step: next register value and the bit leaving the register.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit
);

  // ROR reports the bit wrapped into the MSB, which is the old LSB
  always_comb begin
    next_q  = q;
    out_bit = 1'b0;
    case (mode)
      MODE_LSL: begin
        next_q  = {q[WIDTH-2:0], 1'b0};
        out_bit = q[WIDTH-1];
      end
      MODE_LSR: begin
        next_q  = {1'b0, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_ASR: begin
        next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_ROR: begin
        next_q  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      default: begin
        next_q  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_nb_seq.sv
// Multi-cycle shift unit: latches an operand on start, shifts one bit per clock
// for the requested amount, then pulses done for one cycle with the result held in q.
module shift_nb_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam logic [AMT_W-1:0] CNT_ZERO = AMT_W'(0);
  localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);

  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic [WIDTH-1:0] q_r;
  logic             serial_r;
  logic [AMT_W-1:0] count_r;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] step_q_s;
  logic             step_bit_s;
  logic             busy_s;
  logic             done_s;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .q       (q_r),
    .mode    (mode_r),
    .next_q  (step_q_s),
    .out_bit (step_bit_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; SHIFT exits on count==1 so the counter never wraps
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = (amount != CNT_ZERO) ? ST_SHIFT : ST_DONE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (count_r == CNT_ONE) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Datapath registers: load on accepted start, step while shifting, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r      <= '0;
      serial_r <= 1'b0;
      count_r  <= CNT_ZERO;
      mode_r   <= MODE_LSL;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            q_r      <= load_val;
            serial_r <= 1'b0;
            count_r  <= amount;
            mode_r   <= mode;
          end
        end
        ST_SHIFT: begin
          q_r      <= step_q_s;
          serial_r <= step_bit_s;
          count_r  <= count_r - CNT_ONE;
        end
        default: begin
          q_r      <= q_r;
          serial_r <= serial_r;
          count_r  <= count_r;
          mode_r   <= mode_r;
        end
      endcase
    end
  end

  // Status outputs decoded from the registered state only
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      ST_SHIFT: busy_s = 1'b1;
      ST_DONE:  done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  assign q          = q_r;
  assign serial_out = serial_r;
  assign busy       = busy_s;
  assign done       = done_s;

endmodule
